// File: rtl/microcode_loader.sv
// microcode_loader: streams bytes into little-endian words and writes them into the whole microcode store.
// Optional trailing checksum byte verification is enabled with LOADER_CHECKSUM_EN.
module microcode_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int MICROCODE_SIZE = 24
) (
    input  logic                      clk,
    input  logic                      RESETn,
    input  logic                      start,
    input  logic                      src_valid,
    input  logic [7:0]                src_data,
    output logic                      src_ready,
    output logic [MICROCODE_SIZE-1:0] microcode,
    output logic [ADDR_WIDTH-1:0]     address,
    output logic                      eeprom_in,
    output logic                      eeprom_out,
    output logic                      RESET_counter,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int BYTES = MICROCODE_SIZE / 8;
    localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] TOP = '1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t state, next;
    logic [IW-1:0] byte_idx;
    logic xfer, start_ok;

    assign xfer = src_valid && src_ready;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
    assign src_ready = state == COLLECT || state == CHECK;
    assign busy = state == COLLECT || state == WRITE || state == CHECK;
    assign error = state == ERROR;
`else
    assign src_ready = state == COLLECT;
    assign busy = state == COLLECT || state == WRITE;
    assign error = 1'b0;
`endif
    assign eeprom_in = state == WRITE;
    assign eeprom_out = state == DONE;
    assign done = state == DONE;
    assign RESET_counter = state != DONE;

    always_ff @(posedge clk or negedge RESETn)
        if (!RESETn) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE, ERROR: next = start ? COLLECT : state;
            COLLECT: next = (xfer && byte_idx == LAST) ? WRITE : COLLECT;
`ifdef LOADER_CHECKSUM_EN
            WRITE: next = address == TOP ? CHECK : COLLECT;
            CHECK: next = xfer ? (src_data == checksum ? DONE : ERROR) : CHECK;
`else
            WRITE: next = address == TOP ? DONE : COLLECT;
`endif
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            address <= '0;
            microcode <= '0;
            byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            if (start_ok) begin
                address <= '0;
                byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                checksum <= '0;
`endif
            end
            if (state == COLLECT && xfer) begin
                for (int k = 0; k < BYTES; k++)
                    if (byte_idx == IW'(k)) microcode[8*k +: 8] <= src_data;
                byte_idx <= byte_idx == LAST ? '0 : byte_idx + IW'(1);
`ifdef LOADER_CHECKSUM_EN
                checksum <= checksum + src_data;
`endif
            end
            // the last address holds so the final word stays visible after the load
            if (state == WRITE && address != TOP) address <= address + ADDR_WIDTH'(1);
        end
    end
endmodule
